// File: rtl/uart_tx_arbiter.sv
// Round-robin, message-granular arbiter that shares one byte-wide UART
// transmitter between NUM_REQ message sources.
module uart_tx_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int MAX_MSG_LEN = 64,
  parameter int IDLE_GAP    = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 tx_valid,
  output logic [7:0]           tx_data,
  input  logic                 tx_ready,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 busy,
  output logic                 overrun
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_XFER = 2'd1,
    S_GAP  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]   owner_q, owner_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [7:0]         byte_cnt_q, byte_cnt_d;
  logic [3:0]         gap_cnt_q, gap_cnt_d;
  logic               overrun_q, overrun_d;

  logic [7:0]         req_byte [NUM_REQ];
  logic               in_xfer;
  logic               owner_valid;
  logic               owner_last;
  logic               accept;
  logic [7:0]         cnt_inc;
  logic               hit_max;
  logic               end_of_msg;
  logic [PTR_W-1:0]   owner_next;
  logic               found;
  logic [PTR_W-1:0]   win_idx;
  logic [PTR_W:0]     cand;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign req_byte[gi]  = req_data[8*gi +: 8];
      assign req_ready[gi] = accept & grant_q[gi];
    end
  endgenerate

  // Datapath follows the registered owner; nothing is presented outside XFER.
  assign in_xfer     = (state_q == S_XFER);
  assign owner_valid = req_valid[owner_q];
  assign owner_last  = req_last[owner_q];
  assign tx_valid    = in_xfer & owner_valid;
  assign tx_data     = in_xfer ? req_byte[owner_q] : 8'h00;
  assign accept      = tx_valid & tx_ready;

  assign cnt_inc     = byte_cnt_q + 8'd1;
  assign hit_max     = (cnt_inc == 8'(MAX_MSG_LEN));
  assign end_of_msg  = accept & (owner_last | hit_max);
  assign owner_next  = (owner_q == PTR_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;

  assign grant   = grant_q;
  assign busy    = (state_q != S_IDLE);
  assign overrun = overrun_q;

  // Rotating priority search: first valid at or after rr_ptr, wrapping.
  always_comb begin
    found   = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, rr_ptr_q} + (PTR_W+1)'(k);
      if (cand >= (PTR_W+1)'(NUM_REQ)) begin
        cand = cand - (PTR_W+1)'(NUM_REQ);
      end
      if (!found && req_valid[cand[PTR_W-1:0]]) begin
        found   = 1'b1;
        win_idx = cand[PTR_W-1:0];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    owner_d    = owner_q;
    grant_d    = grant_q;
    byte_cnt_d = byte_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    overrun_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (found) begin
          grant_d          = '0;
          grant_d[win_idx] = 1'b1;
          owner_d          = win_idx;
          byte_cnt_d       = 8'd0;
          state_d          = S_XFER;
        end
      end

      S_XFER: begin
        if (accept) begin
          byte_cnt_d = cnt_inc;
          overrun_d  = hit_max;
        end
        if (end_of_msg) begin
          rr_ptr_d  = owner_next;
          grant_d   = '0;
          gap_cnt_d = 4'd0;
          state_d   = (IDLE_GAP == 0) ? S_IDLE : S_GAP;
        end
      end

      S_GAP: begin
        if (gap_cnt_q == 4'(IDLE_GAP - 1)) begin
          state_d = S_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + 4'd1;
        end
      end

      default: begin
        state_d = S_IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      rr_ptr_q   <= '0;
      owner_q    <= '0;
      grant_q    <= '0;
      byte_cnt_q <= 8'd0;
      gap_cnt_q  <= 4'd0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      owner_q    <= owner_d;
      grant_q    <= grant_d;
      byte_cnt_q <= byte_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      overrun_q  <= overrun_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: per-requester source queues feed the DUT,
// a scoreboard holds the expected (owner, byte) service order.
module tb_uart_tx_arbiter;

  localparam int NR   = 4;
  localparam int MAXL = 4;
  localparam int GAPC = 2;

  logic            clk;
  logic            reset_n;
  logic [NR-1:0]   req_valid;
  logic [8*NR-1:0] req_data;
  logic [NR-1:0]   req_last;
  logic [NR-1:0]   req_ready;
  logic            tx_valid;
  logic [7:0]      tx_data;
  logic            tx_ready;
  logic [NR-1:0]   grant;
  logic            busy;
  logic            overrun;

  uart_tx_arbiter #(
    .NUM_REQ    (NR),
    .MAX_MSG_LEN(MAXL),
    .IDLE_GAP   (GAPC)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .req_valid(req_valid),
    .req_data (req_data),
    .req_last (req_last),
    .req_ready(req_ready),
    .tx_valid (tx_valid),
    .tx_data  (tx_data),
    .tx_ready (tx_ready),
    .grant    (grant),
    .busy     (busy),
    .overrun  (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         vectors     = 0;
  int         miscompares = 0;
  int         sb_req[$];
  logic [7:0] sb_data[$];
  logic [8:0] src_q[NR][$];
  logic [NR-1:0] hold;
  int         acc_cnt   = 0;
  int         ov_cnt    = 0;
  int         acc_at_ov = 0;
  int         ov0;
  int         a0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic src_push(input int r, input logic [7:0] d, input logic last);
    src_q[r].push_back({last, d});
  endtask

  task automatic expect_byte(input int r, input logic [7:0] d);
    sb_req.push_back(r);
    sb_data.push_back(d);
  endtask

  task automatic drive_sources();
    logic [8:0] h;
    for (int i = 0; i < NR; i++) begin
      if (src_q[i].size() > 0 && !hold[i]) begin
        h                  = src_q[i][0];
        req_valid[i]       = 1'b1;
        req_data[8*i +: 8] = h[7:0];
        req_last[i]        = h[8];
      end else begin
        req_valid[i]       = 1'b0;
        req_data[8*i +: 8] = 8'h00;
        req_last[i]        = 1'b0;
      end
    end
  endtask

  // One clock: observe on the falling edge, advance sources after the rising edge.
  task automatic step();
    logic [NR-1:0] acc;
    int            r;
    logic [7:0]    d;
    @(negedge clk);
    acc = req_ready;
    if (overrun) begin
      ov_cnt++;
      acc_at_ov = acc_cnt;
    end
    if (tx_valid && tx_ready) begin
      acc_cnt++;
      check("req_ready_vs_grant", {28'd0, req_ready}, {28'd0, grant});
      vectors++;
      assert (sb_req.size() > 0) else begin
        miscompares++;
        $error("FAIL unexpected_byte observed=0x%0h expected=none", tx_data);
      end
      if (sb_req.size() > 0) begin
        r = sb_req.pop_front();
        d = sb_data.pop_front();
        $display("byte: owner=%0d data=0x%02h (expected owner=%0d data=0x%02h)",
                 $clog2(grant), tx_data, r, d);
        check("tx_data", {24'd0, tx_data}, {24'd0, d});
        check("tx_owner", {28'd0, grant}, 32'(1) << r);
      end
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < NR; i++) begin
      if (acc[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
    end
    drive_sources();
  endtask

  task automatic drain(input string tag, input int budget);
    int n;
    n = 0;
    while (sb_req.size() > 0 && n < budget) begin
      step();
      n++;
    end
    check(tag, sb_req.size(), 0);
    repeat (GAPC + 1) step();
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_grant"},     {28'd0, grant},     32'd0);
    check({tag, "_busy"},      {31'd0, busy},      32'd0);
    check({tag, "_overrun"},   {31'd0, overrun},   32'd0);
    check({tag, "_tx_valid"},  {31'd0, tx_valid},  32'd0);
    check({tag, "_tx_data"},   {24'd0, tx_data},   32'd0);
    check({tag, "_req_ready"}, {28'd0, req_ready}, 32'd0);
  endtask

  task automatic pulse_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n   = 1'b0;
    tx_ready  = 1'b1;
    hold      = '0;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    repeat (2) @(posedge clk);
    #1;
    check_quiet("reset");
    reset_n = 1'b1;

    // Single requester 1: 48 69 0A, then IDLE_GAP cycles of busy.
    src_push(1, 8'h48, 1'b0); src_push(1, 8'h69, 1'b0); src_push(1, 8'h0A, 1'b1);
    expect_byte(1, 8'h48); expect_byte(1, 8'h69); expect_byte(1, 8'h0A);
    drive_sources();
    check("t1_grant_before", {28'd0, grant}, 32'd0);
    step();
    check("t1_grant", {28'd0, grant}, 32'h2);
    step(); step(); step();
    check("t1_grant_drop", {28'd0, grant}, 32'd0);
    check("t1_busy_gap0", {31'd0, busy}, 32'd1);
    step();
    check("t1_busy_gap1", {31'd0, busy}, 32'd1);
    step();
    check("t1_busy_idle", {31'd0, busy}, 32'd0);
    check("t1_sb_empty", sb_req.size(), 0);

    // Fairness from reset: 0 then 2, then 2's turn comes before 0's second message.
    pulse_reset();
    src_push(0, 8'h11, 1'b0); src_push(0, 8'h12, 1'b1);
    src_push(0, 8'h31, 1'b0); src_push(0, 8'h32, 1'b1);
    src_push(2, 8'h21, 1'b0); src_push(2, 8'h22, 1'b1);
    expect_byte(0, 8'h11); expect_byte(0, 8'h12);
    expect_byte(2, 8'h21); expect_byte(2, 8'h22);
    expect_byte(0, 8'h31); expect_byte(0, 8'h32);
    drive_sources();
    drain("fair_drain", 60);

    // Wrap-around: 3 served, pointer wraps to 0, so 0 beats 3.
    src_push(3, 8'h41, 1'b1);
    expect_byte(3, 8'h41);
    drive_sources();
    drain("wrap_d_drain", 30);
    src_push(0, 8'h51, 1'b1); src_push(3, 8'h61, 1'b1);
    expect_byte(0, 8'h51); expect_byte(3, 8'h61);
    drive_sources();
    drain("wrap_drain", 30);

    // Lock: owner 1 stalls its valid while requester 0 waits.
    src_push(1, 8'h71, 1'b0); src_push(1, 8'h72, 1'b0); src_push(1, 8'h73, 1'b1);
    expect_byte(1, 8'h71); expect_byte(1, 8'h72); expect_byte(1, 8'h73);
    expect_byte(0, 8'h81);
    drive_sources();
    step();
    check("lock_grant", {28'd0, grant}, 32'h2);
    step();
    hold[1] = 1'b1;
    src_push(0, 8'h81, 1'b1);
    drive_sources();
    for (int i = 0; i < 5; i++) begin
      step();
      check("lock_hold_grant", {28'd0, grant}, 32'h2);
      check("lock_hold_tx_valid", {31'd0, tx_valid}, 32'd0);
    end
    hold[1] = 1'b0;
    drive_sources();
    drain("lock_drain", 40);

    // Stall: tx_ready low for 10 cycles holds everything still.
    tx_ready = 1'b0;
    src_push(2, 8'h91, 1'b0); src_push(2, 8'h92, 1'b1);
    expect_byte(2, 8'h91); expect_byte(2, 8'h92);
    drive_sources();
    step();
    check("stall_grant", {28'd0, grant}, 32'h4);
    for (int i = 0; i < 10; i++) begin
      step();
      check("stall_req_ready", {28'd0, req_ready}, 32'd0);
      check("stall_tx_data", {24'd0, tx_data}, 32'h91);
      check("stall_tx_valid", {31'd0, tx_valid}, 32'd1);
    end
    tx_ready = 1'b1;
    drain("stall_drain", 30);

    // Last byte coincides with the length limit: release plus one overrun pulse.
    ov0 = ov_cnt;
    a0  = acc_cnt;
    src_push(0, 8'hA0, 1'b0); src_push(0, 8'hA1, 1'b0);
    src_push(0, 8'hA2, 1'b0); src_push(0, 8'hA3, 1'b1);
    expect_byte(0, 8'hA0); expect_byte(0, 8'hA1);
    expect_byte(0, 8'hA2); expect_byte(0, 8'hA3);
    drive_sources();
    drain("coinc_drain", 30);
    check("coinc_ov_count", ov_cnt - ov0, 1);
    check("coinc_ov_pos", acc_at_ov - a0, 4);
    check("coinc_busy", {31'd0, busy}, 32'd0);

    // Overrun: six bytes without last are split 4 + 2 across two grants.
    ov0 = ov_cnt;
    a0  = acc_cnt;
    for (int i = 0; i < 6; i++) begin
      src_push(2, 8'hB0 + 8'(i), 1'b0);
      expect_byte(2, 8'hB0 + 8'(i));
    end
    drive_sources();
    drain("ovr_drain", 60);
    check("ovr_count", ov_cnt - ov0, 1);
    check("ovr_pos", acc_at_ov - a0, 4);
    check("ovr_regrant", {28'd0, grant}, 32'h4);

    // Asynchronous reset after one byte of a three-byte message.
    src_push(2, 8'hC0, 1'b0); src_push(2, 8'hC1, 1'b0); src_push(2, 8'hC2, 1'b1);
    expect_byte(2, 8'hC0);
    drive_sources();
    step();
    check("areset_first_byte", sb_req.size(), 0);
    #2;
    reset_n = 1'b0;
    #1;
    check_quiet("areset");
    for (int i = 0; i < NR; i++) src_q[i].delete();
    drive_sources();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    src_push(0, 8'hD0, 1'b1); src_push(3, 8'hE0, 1'b1);
    expect_byte(0, 8'hD0); expect_byte(3, 8'hE0);
    drive_sources();
    step();
    check("areset_rr_grant", {28'd0, grant}, 32'h1);
    drain("areset_drain", 30);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares a single byte-wide UART transmitter between NUM_REQ message sources, such as an edge-detect greeter, status reporter or debug dumper.
- Arbitration is round-robin at message granularity: once granted, a requester owns the transmitter until it marks its last byte, or until a length limit forces release.
- Sits between the message-producing blocks and the UART shifter, whose byte-accept handshake is tx_valid/tx_ready.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
MAX_MSG_LEN, 64, bytes allowed per grant before forced release (1..255)
IDLE_GAP, 2, cycles of enforced idle between messages (0..15)

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
req_valid  input  NUM_REQ  per-requester byte available
req_data  input  8*NUM_REQ  per-requester byte; requester i uses bits [8i+7:8i]
req_last  input  NUM_REQ  per-requester: current byte is final byte of message
req_ready  output  NUM_REQ  per-requester: byte accepted this cycle
tx_valid  output  1  byte presented to UART transmitter
tx_data  output  8  byte to transmit
tx_ready  input  1  UART transmitter accepts byte this cycle (idle)
grant  output  NUM_REQ  one-hot owner of transmitter; all zero when none
busy  output  1  high in XFER or GAP
overrun  output  1  one-cycle pulse when MAX_MSG_LEN forces release

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low (reset_n).
- While reset_n=0:
  - state=IDLE, rr_ptr=0, byte_cnt=0, gap_cnt=0.
  - grant=0, busy=0, overrun=0, tx_valid=0, tx_data=0, req_ready=0.
  - Reset mid-message abandons it immediately; no partial-message recovery.
- States: IDLE, XFER, GAP.
- IDLE:
  - Each cycle, search req_valid starting at index rr_ptr, wrapping modulo NUM_REQ; the first set bit wins.
  - On a winner: register grant (one-hot), clear byte_cnt, go to XFER.
  - With no valid, stay in IDLE.
  - Latency: req_valid high in IDLE at cycle N gives grant high from cycle N+1.
- XFER:
  - tx_valid = req_valid[g] and tx_data = req_data of g, where g is the granted requester. These are combinational from the registered grant.
  - req_ready[g] = tx_ready & req_valid[g]. All other req_ready are 0.
  - A byte is accepted when tx_valid & tx_ready; byte_cnt increments on accept.
  - Grant is locked while the owner drops req_valid mid-message: tx_valid=0, no timeout.
  - Other requesters' valids are ignored during XFER.
- End of message:
  - Trigger: an accepted byte with req_last[g]=1, or the accepted byte that makes byte_cnt equal MAX_MSG_LEN.
  - In the MAX_MSG_LEN case, overrun pulses for one cycle, in the cycle after the accept.
  - If both conditions coincide: release as normal; overrun still pulses.
  - On end of message: rr_ptr <= (g+1) mod NUM_REQ, grant <= 0, gap_cnt <= 0.
  - Next state is GAP, or IDLE directly if IDLE_GAP=0.
- GAP:
  - tx_valid=0 and grant=0; gap_cnt counts up.
  - Exit to IDLE after IDLE_GAP cycles in GAP.
- busy = (state != IDLE).
- Widths: byte_cnt is 8 bits; gap_cnt is 4 bits; rr_ptr is clog2(NUM_REQ) bits and wraps from NUM_REQ-1 to 0.
- Throughput: one byte per cycle when the owner's valid and tx_ready are continuously high.

Test Plan:
- Single requester: req 1 sends 0x48,0x69,0x0A with last on 0x0A, tx_ready always 1.
  - grant=4'b0010 one cycle after valid.
  - tx_data sequence is 48,69,0A.
  - grant drops after 0A; busy stays high for IDLE_GAP=2 cycles, then low.
- Fairness:
  - Requesters 0 and 2 both valid from reset with 2-byte messages: 0 is served first, then 2.
  - Then requester 0 again, with rr_ptr=1: searching 1,2,3,0, requester 2 is served before 0.
- Wrap-around: requester 3 served, then requesters 0 and 3 both valid; requester 0 wins (rr_ptr wrapped to 0).
- Lock and stall:
  - Owner 1 drops req_valid for 5 cycles mid-message while requester 0 is valid: grant stays 4'b0010, tx_valid=0.
  - With tx_ready held low 10 cycles: no req_ready, byte_cnt unchanged, tx_data stable.
- Overrun: MAX_MSG_LEN=4, requester 2 streams 6 bytes with no last.
  - Exactly 4 bytes are accepted and overrun pulses once.
  - Requester 2 regrants after the gap for the remaining 2 bytes.
- Reset mid-XFER: assert reset_n=0 asynchronously after 1 byte of 3.
  - All outputs go to 0 without waiting for a clock edge.
  - After release, the first grant search starts at requester 0.
